flash_xip_cache: RTL
====================

FLASH_XIP_CACHE -- requirements
Module: flash_xip_cache

Interface
REQ-001 Parameter CACHE_LINES, default 16, number of direct-mapped one-word entries (power of two, 2..64).
REQ-002 Parameter flash_addr_start, default 32'h30000000, lowest cacheable address.
REQ-003 Parameter flash_addr_end, default 32'h3fffffff, highest cacheable address.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_paddr/in_psel/in_penable/in_pprot/in_pwrite/in_pwdata/in_pstrb  input  32/1/1/3/1/32/4  APB slave request from the crossbar.
REQ-007 in_pready/in_prdata/in_pslverr  output  1/32/1  APB slave response.
REQ-008 out_paddr/out_psel/out_penable/out_pprot/out_pwrite/out_pwdata/out_pstrb  output  32/1/1/3/1/32/4  APB master request to the downstream SPI/XIP controller.
REQ-009 out_pready/out_prdata/out_pslverr  input  1/32/1  APB master response.
REQ-010 flush  input  1  one-cycle pulse invalidating all entries.

Function
REQ-011 Cacheable = read with flash_addr_start <= in_paddr <= flash_addr_end; index = in_paddr[2+log2(CACHE_LINES)-1:2], tag = remaining upper bits of in_paddr[27:0].
REQ-012 States: IDLE, HIT_RESP, FWD_SETUP, FWD_ACCESS, RESP.
REQ-013 IDLE: on in_psel && !in_penable, latch addr/write/wdata/strb/prot; cacheable hit -> HIT_RESP; flash-range write -> RESP with in_pslverr=1, nothing forwarded; otherwise -> FWD_SETUP.
REQ-014 HIT_RESP: in_pready=1, in_prdata=stored word, in_pslverr=0 for exactly one cycle, then IDLE (hit latency: response in first access-phase cycle).
REQ-015 FWD_SETUP: out_psel=1, out_penable=0, latched request driven; next cycle FWD_ACCESS.
REQ-016 FWD_ACCESS: out_psel=1, out_penable=1 held until out_pready=1; then out_psel/out_penable drop next cycle, out_prdata/out_pslverr registered, -> RESP.
REQ-017 RESP: in_pready=1 for exactly one cycle with registered data/error, then IDLE.
REQ-018 Fill: cacheable read completing with out_pslverr=0 writes data, tag, valid=1 at its index; out_pslverr=1 leaves entry unchanged.
REQ-019 Non-flash accesses (e.g. SPI registers 32'h10001000-32'h10001fff) always forward, never allocate.
REQ-020 flush clears every valid bit in the cycle it is sampled; flush coincident with a fill: flush wins, entry ends invalid; in-flight transfer still completes and responds.
REQ-021 flush coinciding with IDLE lookup: lookup uses pre-flush valid bits.
REQ-022 in_pready is 0 in IDLE, FWD_SETUP, FWD_ACCESS; out_psel is 0 in IDLE, HIT_RESP, RESP.
REQ-023 Only one outstanding transaction; new setup phases ignored outside IDLE.

Reset
REQ-024 reset -> state IDLE, all valid bits 0, all outputs 0, registered response data 0.
REQ-025 reset mid-transfer aborts: out_psel/out_penable 0 after that edge, no response issued, no fill.

Configuration
REQ-026 Macro FLASH_XIP_CACHE_EN defined: behaviour per REQ-011..REQ-023.
REQ-027 FLASH_XIP_CACHE_EN undefined: no storage; every request forwarded per FWD_SETUP/FWD_ACCESS/RESP, flash-range writes still return in_pslverr=1, flush ignored.

Structure
REQ-028 Shared package holds state encoding, APB field widths, SPI register-window constants (32'h10001000, 32'h10001fff).
REQ-029 One sub-module, flash_xip_cache_array: tag/valid/data storage with lookup port, fill port and flush.

Verification
REQ-030 Read 32'h30000010 cold (downstream returns 32'hDEADBEEF after 5 wait cycles) -> in_pready after forward, in_prdata=32'hDEADBEEF; repeat read -> hit, in_pready in first access cycle, out_psel stays 0.
REQ-031 Read 32'h30000010 then 32'h30000050 (same index, different tag, 16 lines) -> second misses and replaces; re-read 32'h30000010 misses again.
REQ-032 Write 32'h30000000 -> in_pslverr=1, in_pready 1 cycle, out_psel never asserted.
REQ-033 Read 32'h10001004 twice -> both forwarded, no allocation.
REQ-034 Cached 32'h30000020 then flush pulse -> next read forwarded; flush during FWD_ACCESS of a fill -> entry invalid afterwards.
REQ-035 reset asserted in FWD_ACCESS -> out_psel=0 next cycle, no in_pready, subsequent read of same address misses.

Source files
------------

// File: rtl/flash_xip_cache_pkg.sv
// Shared definitions for the flash XIP read cache: FSM encoding, APB field
// widths, request payload and the SPI controller register window.
package flash_xip_cache_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned STRB_W = 4;

    // Address bits that take part in tag/index; the top nibble is left out.
    localparam int unsigned TAG_TOP = 27;

    // SPI/XIP controller register window, never cacheable.
    localparam logic [ADDR_W-1:0] SPI_REG_START = 32'h1000_1000;
    localparam logic [ADDR_W-1:0] SPI_REG_END   = 32'h1000_1fff;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HIT_RESP   = 3'd1,
        ST_FWD_SETUP  = 3'd2,
        ST_FWD_ACCESS = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    // Request captured in the APB setup phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } apb_req_t;

endpackage

// File: rtl/flash_xip_cache_array.sv
// Direct-mapped one-word cache storage: combinational lookup, single fill
// port, and a flush that clears every valid bit (flush beats a same-cycle fill).
module flash_xip_cache_array
    import flash_xip_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 22
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [IDX_W-1:0]  lookup_index,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              lookup_hit_c,
    output logic [DATA_W-1:0] lookup_data_c,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] words [LINES];

    // Valid bits: reset and flush clear all, a fill sets its own line.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tag/data payload; unreset since valid qualifies every read.
    always_ff @(posedge clock) begin
        if (fill_en && !flush && !reset) begin
            tags[fill_index]  <= fill_tag;
            words[fill_index] <= fill_data;
        end
    end

    assign lookup_hit_c  = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
    assign lookup_data_c = words[lookup_index];

endmodule

// File: rtl/flash_xip_cache.sv
// APB-to-APB read cache in front of the SPI/XIP flash controller.
// Build macro FLASH_XIP_CACHE_EN enables the cache; without it every request
// is forwarded and flush is ignored. Flash-range writes always error locally.
module flash_xip_cache
    import flash_xip_cache_pkg::*;
#(
    parameter int unsigned       CACHE_LINES      = 16,
    parameter logic [ADDR_W-1:0] flash_addr_start = 32'h3000_0000,
    parameter logic [ADDR_W-1:0] flash_addr_end   = 32'h3fff_ffff
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [PROT_W-1:0] in_pprot,
    input  logic              in_pwrite,
    input  logic [DATA_W-1:0] in_pwdata,
    input  logic [STRB_W-1:0] in_pstrb,
    output logic              in_pready,
    output logic [DATA_W-1:0] in_prdata,
    output logic              in_pslverr,
    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_psel,
    output logic              out_penable,
    output logic [PROT_W-1:0] out_pprot,
    output logic              out_pwrite,
    output logic [DATA_W-1:0] out_pwdata,
    output logic [STRB_W-1:0] out_pstrb,
    input  logic              out_pready,
    input  logic [DATA_W-1:0] out_prdata,
    input  logic              out_pslverr,
    input  logic              flush
);

    localparam int unsigned IDX_W = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W = TAG_TOP + 1 - 2 - IDX_W;

    state_t            state;
    state_t            next_state;
    apb_req_t          req_q;
    logic [DATA_W-1:0] rdata_q;
    logic              slverr_q;
    logic              cacheable_q;
    logic              pready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pready_d;
    logic              psel_d;
    logic              penable_d;

    logic              setup_c;
    logic              in_flash_c;
    logic              cacheable_c;
    logic              flash_write_c;
    logic              hit_c;
    logic [DATA_W-1:0] hit_data_c;

    assign setup_c       = in_psel && !in_penable;
    assign in_flash_c    = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
    assign cacheable_c   = !in_pwrite && in_flash_c
                         && !((in_paddr >= SPI_REG_START) && (in_paddr <= SPI_REG_END));
    assign flash_write_c = in_pwrite && in_flash_c;

`ifdef FLASH_XIP_CACHE_EN
    logic fill_en_c;
    logic lookup_hit_c;

    assign fill_en_c = (state == ST_FWD_ACCESS) && out_pready && !out_pslverr && cacheable_q;
    assign hit_c     = cacheable_c && lookup_hit_c;

    flash_xip_cache_array #(
        .LINES (CACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .lookup_index  (in_paddr[IDX_W+1:2]),
        .lookup_tag    (in_paddr[TAG_TOP:IDX_W+2]),
        .lookup_hit_c  (lookup_hit_c),
        .lookup_data_c (hit_data_c),
        .fill_en       (fill_en_c),
        .fill_index    (req_q.addr[IDX_W+1:2]),
        .fill_tag      (req_q.addr[TAG_TOP:IDX_W+2]),
        .fill_data     (out_prdata)
    );
`else
    logic unused_c;

    assign unused_c   = ^{flush, cacheable_q};
    assign hit_c      = 1'b0;
    assign hit_data_c = '0;
`endif

    // State register plus the registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pready_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state     <= next_state;
            pready_q  <= pready_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // Next-state decision; setup phases outside IDLE are ignored.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (setup_c) begin
                    if (hit_c)              next_state = ST_HIT_RESP;
                    else if (flash_write_c) next_state = ST_RESP;
                    else                    next_state = ST_FWD_SETUP;
                end
            end
            ST_HIT_RESP:   next_state = ST_IDLE;
            ST_FWD_SETUP:  next_state = ST_FWD_ACCESS;
            ST_FWD_ACCESS: if (out_pready) next_state = ST_RESP;
            ST_RESP:       next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state being entered, then registered.
    always_comb begin
        pready_d  = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        unique case (next_state)
            ST_HIT_RESP, ST_RESP: pready_d = 1'b1;
            ST_FWD_SETUP:         psel_d   = 1'b1;
            ST_FWD_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture and response data/error registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q       <= '0;
            rdata_q     <= '0;
            slverr_q    <= 1'b0;
            cacheable_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && setup_c) begin
                req_q <= '{addr: in_paddr, write: in_pwrite, wdata: in_pwdata,
                           strb: in_pstrb, prot: in_pprot};
                cacheable_q <= cacheable_c;
                if (hit_c) begin
                    rdata_q  <= hit_data_c;
                    slverr_q <= 1'b0;
                end else if (flash_write_c) begin
                    rdata_q  <= '0;
                    slverr_q <= 1'b1;
                end
            end
            if (state == ST_FWD_ACCESS && out_pready) begin
                rdata_q  <= out_prdata;
                slverr_q <= out_pslverr;
            end
        end
    end

    assign in_pready   = pready_q;
    assign in_prdata   = rdata_q;
    assign in_pslverr  = slverr_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_paddr   = req_q.addr;
    assign out_pwrite  = req_q.write;
    assign out_pwdata  = req_q.wdata;
    assign out_pstrb   = req_q.strb;
    assign out_pprot   = req_q.prot;

endmodule
